// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: register-bank controller behind the SPI deserializer.
// Rising edges of txn_valid start a transaction that is captured, decoded and
// then applied as a shadow write, a shadow->active commit, or a rejection.
module spi_reg_ctrl #(
    parameter int         NUM_REGS    = 5,
    parameter logic [6:0] COMMIT_ADDR = 7'h7F,
    parameter bit         AUTO_COMMIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  txn_valid,
    input  logic                  txn_rw,
    input  logic [6:0]            txn_addr,
    input  logic [7:0]            txn_data,
    input  logic                  err_clr,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  commit_pulse,
    output logic                  busy,
    output logic [1:0]            err_code,
    output logic [7:0]            err_count
);

    localparam logic [6:0] ADDR_LIMIT = 7'(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WRITE,
        COMMIT,
        REJECT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       valid_q;
    logic       start;
    logic       overrun;
    logic       hold_rw;
    logic [6:0] hold_addr;
    logic [7:0] hold_data;
    logic       do_write;
    logic       do_commit;
    logic       do_reject;
    logic [1:0] reject_code;
    logic [7:0] shadow [NUM_REGS];
    logic [7:0] active [NUM_REGS];

    assign start   = txn_valid & ~valid_q;
    assign busy    = (state != IDLE);
    assign overrun = start & busy;

    // Remember the previous valid level; resets high so a level already present at release is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b1;
        else     valid_q <= txn_valid;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and one-cycle action enables for the terminal states
    always_comb begin
        next_state  = state;
        do_write    = 1'b0;
        do_commit   = 1'b0;
        do_reject   = 1'b0;
        reject_code = 2'd0;
        case (state)
            IDLE: begin
                if (start) next_state = DECODE;
            end
            DECODE: begin
                if (!hold_rw)                      next_state = REJECT;
                else if (hold_addr < ADDR_LIMIT)   next_state = WRITE;
                else if (hold_addr == COMMIT_ADDR) next_state = COMMIT;
                else                               next_state = REJECT;
            end
            WRITE: begin
                do_write   = 1'b1;
                next_state = IDLE;
            end
            COMMIT: begin
                do_commit  = 1'b1;
                next_state = IDLE;
            end
            REJECT: begin
                do_reject   = 1'b1;
                reject_code = hold_rw ? 2'd2 : 2'd1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the transaction fields only when a new transaction is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rw   <= 1'b0;
            hold_addr <= 7'd0;
            hold_data <= 8'd0;
        end else if (state == IDLE && start) begin
            hold_rw   <= txn_rw;
            hold_addr <= txn_addr;
            hold_data <= txn_data;
        end
    end

    // Shadow and active banks; a full-address compare per register prevents aliasing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= 8'd0;
                active[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (do_write && hold_addr == 7'(i)) begin
                    shadow[i] <= hold_data;
                    if (AUTO_COMMIT) active[i] <= hold_data;
                end
                if (do_commit) active[i] <= shadow[i];
            end
        end
    end

    // Flatten the active bank onto the peripheral bus
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[8*i +: 8] = active[i];
        end
    end

    // Write/commit notification pulses and last written address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_strobe    <= 1'b0;
            commit_pulse <= 1'b0;
            wr_addr      <= 7'd0;
        end else begin
            wr_strobe    <= do_write;
            commit_pulse <= do_commit;
            if (do_write) wr_addr <= hold_addr;
        end
    end

    // Error tracking: clear beats any error, overrun code beats reject code, one increment per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_code  <= 2'd0;
            err_count <= 8'd0;
        end else if (err_clr) begin
            err_code  <= 2'd0;
            err_count <= 8'd0;
        end else if (overrun || do_reject) begin
            err_code <= overrun ? 2'd3 : reject_code;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and randomized checks of spi_reg_ctrl against a
// transaction-level reference model (countdown of remaining edges per transaction).
module tb_spi_reg_ctrl;

    localparam int NR = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          txn_valid;
    logic          txn_rw;
    logic [6:0]    txn_addr;
    logic [7:0]    txn_data;
    logic          err_clr;

    logic [NR*8-1:0] regs_out,     regs_out_ac;
    logic            wr_strobe,    wr_strobe_ac;
    logic [6:0]      wr_addr,      wr_addr_ac;
    logic            commit_pulse, commit_pulse_ac;
    logic            busy,         busy_ac;
    logic [1:0]      err_code,     err_code_ac;
    logic [7:0]      err_count,    err_count_ac;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] sh     [NR];
    logic [7:0] act    [NR];
    logic [7:0] act_ac [NR];
    logic [6:0] m_wr_addr;
    logic [1:0] m_code;
    logic [7:0] m_count;
    logic       m_strobe;
    logic       m_commit;
    int         txn_left;
    logic       prev_valid;
    logic       h_rw;
    logic [6:0] h_addr;
    logic [7:0] h_data;

    spi_reg_ctrl #(.NUM_REGS(NR), .COMMIT_ADDR(7'h7F), .AUTO_COMMIT(1'b0)) dut (
        .clk(clk), .rst(rst), .txn_valid(txn_valid), .txn_rw(txn_rw),
        .txn_addr(txn_addr), .txn_data(txn_data), .err_clr(err_clr),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .commit_pulse(commit_pulse), .busy(busy), .err_code(err_code),
        .err_count(err_count)
    );

    spi_reg_ctrl #(.NUM_REGS(NR), .COMMIT_ADDR(7'h7F), .AUTO_COMMIT(1'b1)) dut_ac (
        .clk(clk), .rst(rst), .txn_valid(txn_valid), .txn_rw(txn_rw),
        .txn_addr(txn_addr), .txn_data(txn_data), .err_clr(err_clr),
        .regs_out(regs_out_ac), .wr_strobe(wr_strobe_ac), .wr_addr(wr_addr_ac),
        .commit_pulse(commit_pulse_ac), .busy(busy_ac), .err_code(err_code_ac),
        .err_count(err_count_ac)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            sh[i] = 8'd0; act[i] = 8'd0; act_ac[i] = 8'd0;
        end
        m_wr_addr = 7'd0; m_code = 2'd0; m_count = 8'd0;
        m_strobe = 1'b0; m_commit = 1'b0;
        txn_left = 0; prev_valid = 1'b1;
        h_rw = 1'b0; h_addr = 7'd0; h_data = 8'd0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelEdge();
        logic       start_now;
        logic       was_busy;
        logic       err;
        logic [1:0] new_code;
        start_now = txn_valid && !prev_valid;
        was_busy  = (txn_left > 0);
        err       = 1'b0;
        new_code  = m_code;
        m_strobe  = 1'b0;
        m_commit  = 1'b0;
        if (txn_left == 1) begin
            if (!h_rw) begin
                err = 1'b1; new_code = 2'd1;
            end else if (h_addr < NR) begin
                sh[h_addr]     = h_data;
                act_ac[h_addr] = h_data;
                m_wr_addr      = h_addr;
                m_strobe       = 1'b1;
            end else if (h_addr == 7'h7F) begin
                for (int i = 0; i < NR; i++) begin
                    act[i] = sh[i]; act_ac[i] = sh[i];
                end
                m_commit = 1'b1;
            end else begin
                err = 1'b1; new_code = 2'd2;
            end
        end
        if (start_now && was_busy) begin
            err = 1'b1; new_code = 2'd3;
        end
        if (was_busy) begin
            txn_left--;
        end else if (start_now) begin
            h_rw = txn_rw; h_addr = txn_addr; h_data = txn_data;
            txn_left = 2;
        end
        if (err_clr) begin
            m_code = 2'd0; m_count = 8'd0;
        end else if (err) begin
            m_code = new_code;
            if (m_count != 8'hFF) m_count++;
        end
        prev_valid = txn_valid;
    endtask

    task automatic checkOutput();
        logic [NR*8-1:0] e;
        logic [NR*8-1:0] eac;
        for (int i = 0; i < NR; i++) begin
            e[8*i +: 8]   = act[i];
            eac[8*i +: 8] = act_ac[i];
        end
        check("regs_out",        regs_out,        e);
        check("wr_strobe",       wr_strobe,       m_strobe);
        check("wr_addr",         wr_addr,         m_wr_addr);
        check("commit_pulse",    commit_pulse,    m_commit);
        check("busy",            busy,            txn_left > 0);
        check("err_code",        err_code,        m_code);
        check("err_count",       err_count,       m_count);
        check("ac_regs_out",     regs_out_ac,     eac);
        check("ac_wr_strobe",    wr_strobe_ac,    m_strobe);
        check("ac_wr_addr",      wr_addr_ac,      m_wr_addr);
        check("ac_commit_pulse", commit_pulse_ac, m_commit);
        check("ac_busy",         busy_ac,         txn_left > 0);
        check("ac_err_code",     err_code_ac,     m_code);
        check("ac_err_count",    err_count_ac,    m_count);
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic [6:0] a,
                                 input logic [7:0] d, input logic clr);
        txn_valid = v; txn_rw = rw; txn_addr = a; txn_data = d; err_clr = clr;
    endtask

    task automatic tick();
        if (!rst) modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // One isolated transaction: valid edge, then valid low with junk fields until idle
    task automatic doTxn(input logic rw, input logic [6:0] a, input logic [7:0] d);
        applyStimulus(1'b1, rw, a, d, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'($urandom), 7'($urandom), 8'($urandom), 1'b0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
        modelReset();
        #1;
        checkOutput();
        @(posedge clk); #1; checkOutput();
        rst = 1'b0;
        tick();

        // Write then commit
        doTxn(1'b1, 7'd2, 8'hA5);
        check("t1_pre_commit_reg2", regs_out[23:16], 8'h00);
        doTxn(1'b1, 7'h7F, 8'h5A);
        check("t1_post_commit", regs_out, 40'h00_00_A5_00_00);

        // Auto-commit instance updates active immediately
        doTxn(1'b1, 7'd0, 8'h3C);
        check("t2_ac_reg0", regs_out_ac[7:0], 8'h3C);
        check("t2_noac_reg0", regs_out[7:0], 8'h00);

        // Read and bad-address rejections
        doTxn(1'b0, 7'd1, 8'hEE);
        check("t3_code_read", err_code, 2'd1);
        doTxn(1'b1, 7'd5, 8'hEE);
        check("t3_code_badaddr", err_code, 2'd2);
        check("t3_count", err_count, 8'd2);

        // Long valid level yields exactly one transaction
        applyStimulus(1'b1, 1'b1, 7'd3, 8'h11, 1'b0);
        repeat (40) tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0);
        tick();
        check("t4_count_after_level", err_count, 8'd2);

        // Overrun on the earliest possible re-start, during a write
        applyStimulus(1'b1, 1'b1, 7'd4, 8'h22, 1'b0); tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0);  tick();
        applyStimulus(1'b1, 1'b1, 7'd1, 8'h99, 1'b0); tick();
        check("t4_overrun_code", err_code, 2'd3);
        check("t4_overrun_count", err_count, 8'd3);
        check("t4_write_done", wr_addr, 7'd4);
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0); tick(); tick();

        // Overrun coinciding with a reject: one increment, overrun code
        applyStimulus(1'b1, 1'b1, 7'd6, 8'h00, 1'b0); tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0);  tick();
        applyStimulus(1'b1, 1'b1, 7'd1, 8'h00, 1'b0); tick();
        check("t4_dual_code", err_code, 2'd3);
        check("t4_dual_count", err_count, 8'd4);
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0); tick(); tick();

        // Saturation, then clear in the same cycle as an error
        repeat (300) doTxn(1'b1, 7'($urandom_range(5, 126)), 8'($urandom));
        check("t5_saturated", err_count, 8'hFF);
        applyStimulus(1'b1, 1'b1, 7'd9, 8'h00, 1'b0); tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0);  tick();
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b1);  tick();
        check("t5_clr_count", err_count, 8'd0);
        check("t5_clr_code", err_code, 2'd0);
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0); tick();

        // Reset in the middle of a write, valid held high through release
        applyStimulus(1'b1, 1'b1, 7'd1, 8'h77, 1'b0); tick();
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput();
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        check("t6_no_write", regs_out_ac, 40'h0);
        applyStimulus(1'b0, 1'b0, 7'd0, 8'd0, 1'b0); tick();
        doTxn(1'b1, 7'd1, 8'h55);
        doTxn(1'b1, 7'h7F, 8'h00);
        check("t6_after_reset", regs_out, 40'h00_00_00_55_00);

        // Randomized traffic: arbitrary valid patterns, mixed addresses, occasional clears
        for (int n = 0; n < 2500; n++) begin
            int r;
            logic [6:0] a;
            r = int'($urandom_range(0, 9));
            if (r < 6)      a = 7'($urandom_range(0, NR - 1));
            else if (r < 8) a = 7'h7F;
            else            a = 7'($urandom_range(NR, 126));
            applyStimulus(($urandom_range(0, 2) != 0), ($urandom_range(0, 7) != 0), a,
                          8'($urandom), ($urandom_range(0, 31) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
